alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequences operations through the shared 32-bit ALU (opcodes 0–13; 64-bit result, HI in [63:32], LO in [31:0]).
- Requesters see a valid/ready request channel and a valid/ready response channel.
- The block latches operands and opcode, holds them stable on the ALU inputs for an opcode-dependent number of settling cycles (multiply and divide are deep combinational paths), then registers the 64-bit result.
- Sits between the control unit and the ALU; only one operation is in flight at a time.

Parameters:
- FAST_CYCLES, 1, EXEC cycles for opcodes 0,1,4–13 (min 1)
- MUL_CYCLES, 4, EXEC cycles for opcode 2 (min 1)
- DIV_CYCLES, 8, EXEC cycles for opcode 3 (min 1)
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_op  in  5  ALU selection code
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_sel  out  5  to ALU selection
- alu_result  in  64  from ALU output
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_hi  out  32  result [63:32]
- rsp_lo  out  32  result [31:0]
- rsp_err  out  1  opcode was illegal (14–31)
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses, wrapping

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous, active-low: sampled only on the rising edge of clk, asserted when clr=0.
- Reset (clr=0 at an edge) sets:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0
  - rsp_hi=rsp_lo=0, alu_a=alu_b=0, alu_sel=0
  - busy=0, op_count=0, cycle counter=0
- Reset overrides all other inputs.
- Reset mid-operation abandons the in-flight op; no response is produced and op_count is unchanged.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - Accept on the edge with req_valid=1.
  - On accept, latch req_a→alu_a, req_b→alu_b, req_op→alu_sel.
  - Legal op (0–13): load counter with N-1 (N per parameters) and go to EXEC.
  - Illegal op (14–31): rsp_hi=rsp_lo=0, rsp_err=1, go directly to RESP; the ALU is never consulted.
- EXEC:
  - req_ready=0; alu_a/alu_b/alu_sel held constant.
  - Counter decrements each cycle.
  - On the edge where counter==0: capture alu_result into rsp_hi/rsp_lo, rsp_err=0, go to RESP.
  - EXEC lasts exactly N cycles.
- RESP:
  - rsp_valid=1; rsp_* held stable; req_ready=0.
  - On the edge with rsp_ready=1: rsp_valid→0, op_count+=1, go to IDLE.
  - rsp_ready while not in RESP is ignored.
- Latency, counted from the accept edge E:
  - rsp_valid is first high in the cycle after edge E+N (N+1 cycles).
  - Illegal op: rsp_valid is high in the cycle after E.
- Back-to-back: a new request cannot be accepted on the same edge as the response handshake. Minimum issue interval is N+2 cycles.
- alu_a/alu_b/alu_sel retain the last operation's values in RESP and IDLE; they change only on accept.
- op_count wraps from 2^CNT_W-1 to 0. Illegal-op responses also count.
- rsp_hi/rsp_lo/rsp_err retain their values after the handshake until the next capture.
- busy = (state != IDLE), registered consistently with state.

Test Plan:
- Reset: hold clr=0 for 2 cycles with req_valid=1 → all outputs at reset values, no accept; release → req_ready=1.
- ADD: A=5, B=7, op=0, rsp_ready=1 → alu_sel=0 held 1 cycle, rsp_valid 2 cycles after accept, rsp_lo=12, rsp_hi=0, rsp_err=0, op_count=1.
- MUL with default MUL_CYCLES=4: A=0x10000, B=0x10000, op=2 → alu inputs stable 4 EXEC cycles, rsp_hi=1, rsp_lo=0, rsp_valid 5 cycles after accept.
- Backpressure: op=4 (AND), A=0xF0F0F0F0, B=0xFF00FF00, rsp_ready=0 for 10 cycles → rsp_valid stays 1, rsp_lo=0xF000F000 stable, req_valid ignored; rsp_ready=1 → handshake, IDLE next cycle.
- Illegal op=20 → rsp_valid 1 cycle after accept, rsp_err=1, rsp_hi=rsp_lo=0, op_count increments.
- Reset mid-DIV: op=3, clr=0 on the 3rd EXEC cycle → IDLE, rsp_valid never asserted, op_count unchanged. Also preload op_count to 0xFFFF via repeated ops, complete one more → op_count=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Single-issue sequencer in front of the shared 32-bit ALU: latches a request,
// holds the ALU inputs for an opcode-dependent settling time, then registers the result.
module alu_op_sequencer #(
  parameter int FAST_CYCLES = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [4:0]       req_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_sel,
  input  logic [63:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_hi,
  output logic [31:0]      rsp_lo,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // state | meaning
  // IDLE  | ready for a request, ALU inputs hold the last operation
  // EXEC  | ALU inputs held while the result settles, timer counts down
  // RESP  | result presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int TMR_W = 16;

  state_t             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [TMR_W-1:0]   tmr_load_d;
  logic               op_legal_d;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [31:0]        rsp_hi_q;
  logic [31:0]        rsp_lo_q;
  logic [31:0]        alu_a_q;
  logic [31:0]        alu_b_q;
  logic [4:0]         alu_sel_q;
  logic               busy_q;
  logic [CNT_W-1:0]   op_count_q;

  always_comb begin
    op_legal_d = (req_op <= 5'd13);
    case (req_op)
      5'd2:    tmr_load_d = TMR_W'(MUL_CYCLES - 1);
      5'd3:    tmr_load_d = TMR_W'(DIV_CYCLES - 1);
      default: tmr_load_d = TMR_W'(FAST_CYCLES - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            alu_a_q     <= req_a;
            alu_b_q     <= req_b;
            alu_sel_q   <= req_op;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (op_legal_d) begin
              tmr_q   <= tmr_load_d;
              state_q <= EXEC;
            end else begin
              // illegal opcodes bypass the ALU entirely
              rsp_hi_q    <= '0;
              rsp_lo_q    <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        EXEC: begin
          if (tmr_q == '0) begin
            rsp_hi_q    <= alu_result[63:32];
            rsp_lo_q    <= alu_result[31:0];
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_W'(1);
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; a second instance with a 4-bit counter
// shares all inputs so counter wrap can be reached quickly.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_op;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_sel;
  logic [63:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_hi, rsp_lo;
  logic        rsp_err, busy;
  logic [15:0] op_count;

  logic        w_req_ready, w_rsp_valid, w_rsp_err, w_busy;
  logic [31:0] w_alu_a, w_alu_b, w_rsp_hi, w_rsp_lo;
  logic [4:0]  w_alu_sel;
  logic [3:0]  w_op_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  alu_op_sequencer u_dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  alu_op_sequencer #(.CNT_W(4)) u_wrap (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sel(w_alu_sel), .alu_result(alu_result),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(w_rsp_hi), .rsp_lo(w_rsp_lo),
    .rsp_err(w_rsp_err), .busy(w_busy), .op_count(w_op_count)
  );

  // behavioural ALU: add, multiply, divide (hi=remainder, lo=quotient), and
  always_comb begin
    alu_result = {32'hDEAD_BEEF, alu_a ^ alu_b};
    case (alu_sel)
      5'd0: alu_result = {32'd0, alu_a + alu_b};
      5'd2: alu_result = {32'd0, alu_a} * {32'd0, alu_b};
      5'd3: if (alu_b != 0) alu_result = {alu_a % alu_b, alu_a / alu_b};
      5'd4: alu_result = {32'd0, alu_a & alu_b};
      default: ;
    endcase
  end

  // stimulus helper: issue one request, wait (bounded) for rsp_valid
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        output int lat, output bit stable);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    stable = 1'b1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (alu_a !== a || alu_b !== b || alu_sel !== op) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (alu_a !== a || alu_b !== b || alu_sel !== op) stable = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 16'd1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy got %b%b exp 00", rsp_valid, busy); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0h exp 0", op_count); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 69'd0) begin errors++; $display("FAIL reset_alu got %h %h %h exp 0", alu_a, alu_b, alu_sel); end
    checks++; if ({rsp_hi, rsp_lo, rsp_err} !== 65'd0) begin errors++; $display("FAIL reset_rsp got %h %h %b exp 0", rsp_hi, rsp_lo, rsp_err); end
    clr = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL release_idle got rdy=%b busy=%b exp 1 0", req_ready, busy); end
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    req_a = 32'd100; req_b = 32'd7; req_op = 5'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy got %b exp 1", busy); end
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL middiv_idle got busy=%b rdy=%b vld=%b exp 0 1 0", busy, req_ready, rsp_valid); end
    checks++; if (op_count !== exp_count || alu_sel !== 5'd0) begin
      errors++; $display("FAIL middiv_state got cnt=%0d sel=%0d exp %0d 0", op_count, alu_sel, exp_count); end
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL middiv_no_rsp got rsp_valid seen exp none"); end
  endtask

  task automatic test_add();
    int lat; bit st;
    run_op(32'd5, 32'd7, 5'd0, lat, st);
    checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL add_alu_hold got unstable exp stable"); end
    checks++; if ({rsp_hi, rsp_lo} !== 64'd12 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL add_result got %h_%h err=%b exp 0_0000000c err=0", rsp_hi, rsp_lo, rsp_err); end
    take_rsp();
    checks++; if (op_count !== exp_count || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_handshake got cnt=%0d vld=%b busy=%b exp %0d 0 0", op_count, rsp_valid, busy, exp_count); end
  endtask

  task automatic test_mul();
    int lat; bit st;
    run_op(32'h0001_0000, 32'h0001_0000, 5'd2, lat, st);
    checks++; if (lat != 5) begin errors++; $display("FAIL mul_latency got %0d exp 5", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mul_alu_hold got unstable exp stable"); end
    checks++; if (rsp_hi !== 32'd1 || rsp_lo !== 32'd0) begin errors++; $display("FAIL mul_result got %h_%h exp 00000001_00000000", rsp_hi, rsp_lo); end
    take_rsp();
  endtask

  task automatic test_div();
    int lat; bit st;
    run_op(32'd100, 32'd7, 5'd3, lat, st);
    checks++; if (lat != 9) begin errors++; $display("FAIL div_latency got %0d exp 9", lat); end
    checks++; if (rsp_hi !== 32'd2 || rsp_lo !== 32'd14 || st !== 1'b1) begin
      errors++; $display("FAIL div_result got %0d_%0d stable=%b exp 2_14 stable=1", rsp_hi, rsp_lo, st); end
    take_rsp();
  endtask

  task automatic test_backpressure();
    int lat; bit st; bit bad;
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4, lat, st);
    checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", lat); end
    bad = 1'b0;
    req_a = 32'h1111_1111; req_b = 32'h2222_2222; req_op = 5'd0; req_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_lo !== 32'hF000_F000 || req_ready !== 1'b0) bad = 1'b1;
    end
    req_valid = 1'b0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bp_hold got lo=%h vld=%b exp f000f000 1", rsp_lo, rsp_valid); end
    checks++; if (alu_a !== 32'hF0F0_F0F0 || alu_sel !== 5'd4) begin
      errors++; $display("FAIL bp_req_ignored got a=%h sel=%0d exp f0f0f0f0 4", alu_a, alu_sel); end
    take_rsp();
    checks++; if (op_count !== exp_count || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got cnt=%0d busy=%b rdy=%b exp %0d 0 1", op_count, busy, req_ready, exp_count); end
  endtask

  task automatic test_illegal();
    int lat; bit st;
    run_op(32'hAAAA_0001, 32'h5555_0002, 5'd20, lat, st);
    checks++; if (lat != 1) begin errors++; $display("FAIL illegal_latency got %0d exp 1", lat); end
    checks++; if (rsp_err !== 1'b1 || rsp_hi !== 32'd0 || rsp_lo !== 32'd0) begin
      errors++; $display("FAIL illegal_rsp got err=%b %h_%h exp 1 0_0", rsp_err, rsp_hi, rsp_lo); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL illegal_alu_latch got sel=%0d exp 20", alu_sel); end
    take_rsp();
    checks++; if (op_count !== exp_count || rsp_err !== 1'b1) begin
      errors++; $display("FAIL illegal_count got cnt=%0d err=%b exp %0d 1", op_count, rsp_err, exp_count); end
  endtask

  task automatic test_back_to_back();
    req_a = 32'd1; req_b = 32'd2; req_op = 5'd0; req_valid = 1'b1; rsp_ready = 1'b1;
    repeat (9) @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    exp_count = exp_count + 16'd3;
    checks++; if (op_count !== exp_count) begin errors++; $display("FAIL b2b_issue_rate got %0d exp %0d", op_count, exp_count); end
    checks++; if (busy !== 1'b0 || rsp_lo !== 32'd3) begin errors++; $display("FAIL b2b_end got busy=%b lo=%0d exp 0 3", busy, rsp_lo); end
  endtask

  task automatic test_wrap();
    int lat; bit st;
    for (int i = 0; i < 16 && exp_count[3:0] != 4'hF; i++) begin
      run_op(32'd0, 32'd0, 5'd31, lat, st);
      take_rsp();
    end
    checks++; if (w_op_count !== 4'hF) begin errors++; $display("FAIL wrap_pre got %0h exp f", w_op_count); end
    run_op(32'd0, 32'd0, 5'd14, lat, st);
    take_rsp();
    checks++; if (w_op_count !== 4'h0) begin errors++; $display("FAIL wrap_zero got %0h exp 0", w_op_count); end
    checks++; if (op_count !== exp_count) begin errors++; $display("FAIL wrap_main_count got %0d exp %0d", op_count, exp_count); end
  endtask

  initial begin
    clr = 1'b0; req_valid = 1'b1; req_a = 32'h1234; req_b = 32'h1; req_op = 5'd0; rsp_ready = 1'b1;
    test_reset();
    test_reset_mid_div();
    test_add();
    test_mul();
    test_div();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
